// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : state encoding and baud defaults shared by the UART rx/tx pair
// Rev 1.0
// ============================================================================
package uart_pkg;

  localparam int SERIAL_COMM_DEF = 115200;
  localparam int CLK_SPEED_DEF   = 100_000_000;

  // Encoding is fixed so the transmitter decodes the same state values
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_speed, input int baud);
    return clk_speed / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// uart_rx_if : serial pin, enable and received-byte signals of the receiver
// Rev 1.0
// ============================================================================
interface uart_rx_if;

  logic       en;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output en, rx,
    input  rx_data, rx_valid, frame_err, rx_busy
  );

  modport slave (
    input  en, rx,
    output rx_data, rx_valid, frame_err, rx_busy
  );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// sync_2ff : generic two-flop synchroniser for asynchronous inputs
// Rev 1.0
// ============================================================================
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8N1 receiver, mid-bit sampling, one-cycle valid / framing strobes
// Rev 1.0
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int SERIAL_COMM = SERIAL_COMM_DEF,
  parameter int CLK_SPEED   = CLK_SPEED_DEF,
  parameter int TICK        = clks_per_bit(CLK_SPEED, SERIAL_COMM),
  parameter int HALF        = TICK / 2
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int             CW        = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [CW-1:0]  TICK_LAST = CW'(TICK - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

  logic        rx_s;
  logic        rx_prev_q;
  uart_state_e state_q;
  logic [CW-1:0] count_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shreg_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        frame_err_q;
  logic        rx_busy_q;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      count_q     <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      // Edge history keeps tracking while disabled so re-enabling on a low line cannot fake a start
      rx_prev_q   <= rx_s;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (!bus.en) begin
        state_q   <= IDLE;
        count_q   <= '0;
        bit_idx_q <= '0;
        rx_busy_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            count_q   <= '0;
            rx_busy_q <= 1'b0;
            if (rx_prev_q && !rx_s) begin
              state_q   <= START;
              rx_busy_q <= 1'b1;
            end
          end
          START: begin
            if (count_q == HALF_LAST) begin
              count_q <= '0;
              if (rx_s) begin
                state_q   <= IDLE;
                rx_busy_q <= 1'b0;
              end else begin
                state_q   <= DATA;
                bit_idx_q <= '0;
              end
            end else begin
              count_q <= count_q + CNT_ONE;
            end
          end
          DATA: begin
            if (count_q == TICK_LAST) begin
              count_q <= '0;
              shreg_q <= {rx_s, shreg_q[7:1]};
              if (bit_idx_q == 3'd7) begin
                state_q <= STOP;
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end else begin
              count_q <= count_q + CNT_ONE;
            end
          end
          STOP: begin
            // Leaving at the stop-bit centre leaves half a bit to catch a gapless next start
            if (count_q == TICK_LAST) begin
              count_q   <= '0;
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
              if (rx_s) begin
                rx_data_q  <= shreg_q;
                rx_valid_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end else begin
              count_q <= count_q + CNT_ONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_busy   = rx_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_rx : scoreboard bench for uart_rx with a behavioural serial source
// Rev 1.0
// ============================================================================
module tb_uart_rx;

  localparam int SERIAL_COMM = 100_000;
  localparam int CLK_SPEED   = 1_600_000;
  localparam int TICK        = 16;
  localparam int HALF        = 8;
  localparam int CLK_T       = 100;
  localparam int BIT_T       = TICK * CLK_T;
  localparam int BIT_FAST    = BIT_T * 102 / 100;
  localparam int BIT_SLOW    = BIT_T * 98 / 100;
  localparam int LAT_EXP     = 3 + HALF + 9 * TICK;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  logic [7:0] model_last = 8'h00;

  uart_rx_if bus();

  uart_rx #(
    .SERIAL_COMM (SERIAL_COMM),
    .CLK_SPEED   (CLK_SPEED),
    .TICK        (TICK),
    .HALF        (HALF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #(CLK_T / 2) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic ferr, input logic [7:0] d);
    exp_t e;
    e.ferr = ferr;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_t, input int nsym);
    logic [9:0] sym;
    sym = {stop, d, 1'b0};
    for (int i = 0; i < nsym; i++) begin
      bus.rx = sym[i];
      #(bit_t);
    end
  endtask

  task automatic send_exp(input logic [7:0] d, input logic stop, input int bit_t);
    push_exp(!stop, d);
    send_frame(d, stop, bit_t, 10);
  endtask

  task automatic wait_drain(input int max_cycles);
    int k;
    k = 0;
    while (q.size() != 0 && k < max_cycles) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d events outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic align();
    @(posedge clk);
    #20;
  endtask

  // Scoreboard monitor: every strobe pops one expected event
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_last = 8'h00;
        total++;
        if (bus.rx_data !== 8'h00 || bus.rx_valid !== 1'b0 ||
            bus.frame_err !== 1'b0 || bus.rx_busy !== 1'b0) begin
          bad++;
          $display("FAIL reset_state: data=%h valid=%b ferr=%b busy=%b required 00/0/0/0",
                   bus.rx_data, bus.rx_valid, bus.frame_err, bus.rx_busy);
        end
      end else begin
        if (bus.rx_valid === 1'b1 && bus.frame_err === 1'b1) begin
          total++;
          bad++;
          $display("FAIL strobe_overlap: valid=1 ferr=1 required not both");
        end
        if (bus.rx_valid === 1'b1 || bus.frame_err === 1'b1) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_strobe: valid=%b ferr=%b data=%h required no strobe",
                     bus.rx_valid, bus.frame_err, bus.rx_data);
          end else begin
            e = q.pop_front();
            if (!e.ferr) model_last = e.data;
            if (bus.frame_err !== e.ferr || bus.rx_valid !== ~e.ferr || bus.rx_data !== model_last) begin
              bad++;
              $display("FAIL rx_event: valid=%b ferr=%b data=%h required valid=%b ferr=%b data=%h",
                       bus.rx_valid, bus.frame_err, bus.rx_data, ~e.ferr, e.ferr, model_last);
            end
          end
        end
      end
    end
  end

  initial begin
    #(CLK_T * 100_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        busy_h [0:255];
    int          lat;
    int          cnt;
    logic [7:0]  perm [256];
    logic [7:0]  tmp;
    logic [7:0]  d;
    logic        stop;
    int          j;

    bus.en = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #20;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Good byte with latency and busy window
    align();
    lat = -1;
    for (int n = 0; n < 256; n++) busy_h[n] = 1'b0;
    push_exp(1'b0, 8'hA5);
    fork
      send_frame(8'hA5, 1'b1, BIT_T, 10);
      for (int n = 1; n < 200; n++) begin
        @(posedge clk);
        @(negedge clk);
        busy_h[n] = bus.rx_busy;
        if (bus.rx_valid === 1'b1 && lat < 0) lat = n;
      end
    join
    check("valid_latency", lat, LAT_EXP);
    check("busy_before_detect", busy_h[2], 1'b0);
    check("busy_after_detect", busy_h[3], 1'b1);
    check("busy_last_cycle", busy_h[LAT_EXP-1], 1'b1);
    check("busy_cleared", busy_h[LAT_EXP], 1'b0);
    wait_drain(400);
    check("good_data", bus.rx_data, 8'hA5);

    // Back-to-back frames, no idle gap
    align();
    send_exp(8'h00, 1'b1, BIT_T);
    send_exp(8'hFF, 1'b1, BIT_T);
    send_exp(8'h55, 1'b1, BIT_T);
    wait_drain(400);
    check("b2b_last_data", bus.rx_data, 8'h55);

    // Glitch shorter than half a bit
    align();
    for (int n = 0; n < 256; n++) busy_h[n] = 1'b0;
    fork
      begin
        bus.rx = 1'b0;
        #(4 * CLK_T);
        bus.rx = 1'b1;
      end
      for (int n = 1; n < 40; n++) begin
        @(posedge clk);
        @(negedge clk);
        busy_h[n] = bus.rx_busy;
      end
    join
    check("glitch_busy_start", busy_h[HALF+2], 1'b1);
    check("glitch_busy_end", busy_h[HALF+3], 1'b0);
    check("glitch_data_held", bus.rx_data, 8'h55);

    // Framing error followed by a held break
    align();
    send_exp(8'h11, 1'b1, BIT_T);
    wait_drain(400);
    align();
    send_exp(8'h3C, 1'b0, BIT_T);
    wait_drain(400);
    cnt = 0;
    for (int n = 0; n < 3 * 10 * TICK; n++) begin
      @(negedge clk);
      if (bus.rx_busy === 1'b1) cnt++;
    end
    check("break_no_retrigger", cnt, 0);
    check("ferr_data_held", bus.rx_data, 8'h11);
    bus.rx = 1'b1;
    #(2 * BIT_T);
    align();
    send_exp(8'h42, 1'b1, BIT_T);
    wait_drain(400);

    // Reset during data bit 4
    align();
    send_frame(8'hC3, 1'b1, BIT_T, 5);
    bus.rx = 1'b1 & 8'hC3 >> 4;
    #(BIT_T / 2);
    check("busy_before_reset", bus.rx_busy, 1'b1);
    rst_n = 1'b0;
    #10;
    check("abort_rst_data", bus.rx_data, 8'h00);
    check("abort_rst_valid", bus.rx_valid, 1'b0);
    check("abort_rst_ferr", bus.frame_err, 1'b0);
    check("abort_rst_busy", bus.rx_busy, 1'b0);
    bus.rx = 1'b1;
    repeat (4) @(posedge clk);
    #20;
    rst_n = 1'b1;
    repeat (2 * TICK) @(posedge clk);
    align();
    send_exp(8'h81, 1'b1, BIT_T);
    wait_drain(400);

    // Enable dropped during data bit 4
    align();
    send_frame(8'h96, 1'b1, BIT_T, 5);
    bus.rx = 1'b1;
    #(BIT_T / 2);
    bus.en = 1'b0;
    repeat (2) @(posedge clk);
    #20;
    check("en_abort_busy", bus.rx_busy, 1'b0);
    #(5 * BIT_T);
    check("en_abort_data_held", bus.rx_data, 8'h81);
    align();
    bus.en = 1'b1;
    repeat (4) @(posedge clk);
    align();
    send_exp(8'h81, 1'b1, BIT_T);
    wait_drain(400);

    // Random frames, occasional bad stop bit
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom_range(255, 0));
      stop = ($urandom_range(3, 0) != 0);
      repeat ($urandom_range(3, 0)) @(posedge clk);
      align();
      send_exp(d, stop, BIT_T);
      if (!stop) begin
        bus.rx = 1'b1;
        #(2 * BIT_T);
      end
      wait_drain(400);
    end

    // Loopback sweep of every byte value in random order, alternating +/-2% rate
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j       = $urandom_range(i, 0);
      tmp     = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      align();
      send_exp(perm[i], 1'b1, (i % 2 == 0) ? BIT_FAST : BIT_SLOW);
    end
    wait_drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Receive half of the board's serial link. It takes the asynchronous `rx` pin, synchronises it, and finds each start bit. It samples 8N1 frames (start bit, 8 data bits LSB first, 1 stop bit) at mid-bit and presents each good byte with a single-cycle valid strobe. It sits beside the transmitter and uses the same baud parameters, so a looped-back `tx` → `rx` returns every byte unchanged.

## Interface
- `SERIAL_COMM`, 115200: baud rate.
- `CLK_SPEED`, 100_000_000: `clk` frequency in Hz.
- `TICK`, `CLK_SPEED/SERIAL_COMM` (868): clocks per bit.
- `HALF`, `TICK/2` (434): clocks from start-bit edge to start-bit centre.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: block enable. When low, the block is synchronously held in IDLE.
- `rx` in 1: serial input, asynchronous. Idle level is high.
- `rx_data` out 8: last good byte. Held until the next good byte.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `frame_err` out 1: one-cycle pulse when the stop bit samples 0.
- `rx_busy` out 1: high from start-edge detect until the frame ends.

## Operation
- Synchroniser: `rx` passes through 2 flops, then a third flop `rx_prev` for edge detection. All three reset to 1.
- Counter `count` is `$clog2(TICK)` bits wide. `bit_idx` is 3 bits. `shreg` is 8 bits.
- IDLE:
  - `count`=0, `rx_busy`=0.
  - A falling edge (`rx_prev`=1, `rx_s`=0) → START, `rx_busy`←1.
  - A line that is already low never triggers a frame; a line held in break does not retrigger.
- START:
  - `count` increments each clock.
  - At `count`==HALF-1, sample `rx_s`:
    - 1 → false start: go to IDLE, `rx_busy`←0, no strobe.
    - 0 → go to DATA, `count`←0, `bit_idx`←0.
- DATA:
  - At `count`==TICK-1, `shreg`←{`rx_s`, `shreg[7:1]`} (LSB first) and `count`←0.
  - If `bit_idx`==7 → STOP; otherwise `bit_idx`+1.
- STOP: at `count`==TICK-1, sample `rx_s`:
  - 1 → `rx_data`←`shreg`, `rx_valid`←1 for one cycle.
  - 0 → `frame_err`←1 for one cycle; `rx_data` unchanged.
  - Either case → IDLE, `rx_busy`←0.
- `rx_valid` and `frame_err` are never high in the same cycle.
- `en` low, at any point: state←IDLE; `count`, `bit_idx`, `rx_busy`, `rx_valid` and `frame_err` ←0. `rx_data` is held. A partial byte is discarded silently.
- `rst_n` low, at any point (including mid-frame): all state clears immediately. `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `rx_busy`=0, state=IDLE, synchroniser=1.

## Timing
- Pin to edge detect: 2–3 clocks (synchroniser depth plus phase). Call the detect cycle E.
- Start-bit check: evaluated at E+HALF.
- Data bit k (k=0..7): sampled at E+HALF+(k+1)·TICK.
- Stop bit: sampled at E+HALF+9·TICK.
- `rx_valid`/`frame_err`: visible in the cycle after E+HALF+9·TICK. With defaults that is E+8247.
- `rx_busy`: high from E+1 through E+HALF+9·TICK, inclusive.
- Back-to-back frames: a start edge arriving immediately after the stop-bit centre is detected.
  - The sampler returns to IDLE half a bit before the end of the stop bit, so zero idle gap between frames is supported.
- Tolerance: mid-bit sampling must accept a ±2% baud mismatch over a full frame.

## Structure
- Shared package `uart_pkg`:
  - State encoding IDLE/START/DATA/STOP as a 2-bit localparam, shared with the transmitter.
  - Defaults for `SERIAL_COMM` and `CLK_SPEED`.
- Sub-module `sync_2ff`: a generic 2-flop synchroniser with a reset value parameter, set to 1 here. Reusable for other asynchronous inputs.
- Everything else is a single module with one FSM process.

## Test plan
- **Good byte:** send 0xA5 at 115200. Expect `rx_data`=0xA5, exactly one `rx_valid` pulse at E+8247, and `frame_err` never high.
- **Back-to-back:** send 0x00, 0xFF, 0x55 with zero idle gap. Expect three `rx_valid` pulses with data 0x00, 0xFF, 0x55.
- **Glitch rejection:** drive `rx` low for 100 clocks, then high. Expect no strobe, `rx_busy` back to 0 at E+HALF, and `rx_data` unchanged.
- **Framing error:** send 0x3C with stop bit 0 after a prior good 0x11. Expect one `frame_err` pulse, `rx_data` still 0x11, and no new frame until `rx` goes high and then falls again.
- **Abort mid-frame:**
  - Assert `rst_n`=0 during bit 4 → all outputs reach their reset values immediately.
  - Separately, drop `en` during bit 4 → no strobe, `rx_data` held.
  - After release in both cases, a clean 0x81 is received correctly.
- **Loopback with rate offset:** transmitter output feeds `rx`, with the receiver clock 2% fast and then 2% slow. 256 bytes (0x00–0xFF) are all received correctly.
